// File: rtl/data_mem_responder_if.sv
// Data-port bus between a load/store master and the data memory.
// Request channel carries dir/addr/wdata/be; response returns rdata/err.
interface data_mem_responder_if #(
   parameter int unsigned WORD_SIZE = 32
);
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_dir;
   logic [WORD_SIZE-1:0] req_addr;
   logic [WORD_SIZE-1:0] req_wdata;
   logic [3:0]           req_be;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [WORD_SIZE-1:0] rsp_rdata;
   logic                 rsp_err;

   modport master (
      output req_valid, req_dir, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_dir, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory: byte-lane writes, fixed-latency
// responses with misalign/range error, backpressured response channel.
module data_mem_responder #(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   data_mem_responder_if.slave  bus
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] LAT = 4'(LATENCY);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0]   mem_q [DEPTH];
   logic [29:0]   widx;
   logic [AW-1:0] idx;
   logic          req_err;
   logic          acc;

   // Range check uses the whole word index so high addresses never alias.
   assign widx    = bus.req_addr[31:2];
   assign idx     = widx[AW-1:0];
   assign req_err = (bus.req_addr[1:0] != 2'b00) ||
                    (widx >= 30'(DEPTH));
   assign acc     = bus.req_valid && bus.req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (acc) begin
               state_d = S_WAIT;
               cnt_d   = LAT;
               err_d   = req_err;
               rdata_d = (!bus.req_dir && !req_err) ? mem_q[idx] : '0;
            end
         end
         S_WAIT: begin
            if (cnt_q <= 4'd1) begin
               state_d = S_RESP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = (state_q == S_IDLE) && rst_n;
      bus.rsp_valid = (state_q == S_RESP);
      bus.rsp_rdata = rdata_q;
      bus.rsp_err   = err_q;
   end

   // Array is deliberately not reset; contents survive rst_n.
   always_ff @(posedge clk) begin
      if (acc && bus.req_dir && !req_err) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.req_be[b]) mem_q[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
         end
      end
   end
endmodule
